// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry for the RW0 SRAM requester controller.
package sram_ctrl_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int DATA_W_DEF     = 72;
  localparam int DEPTH_DEF      = 256;
  localparam int RESP_DEPTH_DEF = 3;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/sram_resp_fifo.sv
// Read-response FIFO: small register array with simultaneous push/pop.
module sram_resp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RESP_DEPTH = RESP_DEPTH_DEF,
  localparam int CNT_W     = $clog2(RESP_DEPTH + 1),
  localparam int PTR_W     = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [RESP_DEPTH];
  logic [DATA_W-1:0] mem_d [RESP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pop_do;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(RESP_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    pop_do   = pop && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_do) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop_do})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is datapath only; validity is tracked by count_q.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == '0);

endmodule

// File: rtl/sram_rw0_ctrl.sv
// Requester-side controller for a single-port RW0 SRAM: zero-fill after reset,
// valid/ready request channel, credit-gated reads into a response FIFO.
module sram_rw0_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int DEPTH         = DEPTH_DEF,
  parameter int RESP_DEPTH    = RESP_DEPTH_DEF,
  parameter int INIT_ON_RESET = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);

  localparam int     CNT_W       = $clog2(RESP_DEPTH + 1);
  localparam state_e RESET_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              inflight_q, inflight_d;

  logic              run;
  logic              credit_ok;
  logic              req_fire;
  logic              rd_fire;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;

  // Outputs are qualified with reset_n so the macro and the request side stay
  // idle while reset is held, whichever state the FSM resets into.
  always_comb begin
    run       = reset_n && (state_q == ST_RUN);
    credit_ok = ({1'b0, fifo_count} + (CNT_W + 1)'(inflight_q)) < (CNT_W + 1)'(RESP_DEPTH);
    req_ready = run && (req_wen || credit_ok);
    req_fire  = req_valid && req_ready;
    rd_fire   = req_fire && !req_wen;
    init_done = run;

    RW0_en    = 1'b0;
    RW0_wmode = 1'b0;
    RW0_addr  = '0;
    RW0_wdata = '0;
    if (reset_n && (state_q == ST_INIT)) begin
      RW0_en    = 1'b1;
      RW0_wmode = 1'b1;
      RW0_addr  = init_cnt_q;
    end else if (run) begin
      RW0_en    = req_fire;
      RW0_wmode = req_wen;
      RW0_addr  = req_addr;
      RW0_wdata = req_wdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    inflight_d = rd_fire;
    if (state_q == ST_INIT) begin
      if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
        state_d    = ST_RUN;
        init_cnt_d = '0;
      end else begin
        init_cnt_d = init_cnt_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RESET_STATE;
      init_cnt_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  // Read data is only valid the cycle after the read; capture it then, the
  // credit check at accept time guarantees a free slot.
  sram_resp_fifo #(
    .DATA_W     (DATA_W),
    .RESP_DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (inflight_q),
    .push_data (RW0_rdata),
    .pop       (resp_ready),
    .pop_data  (resp_rdata),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign resp_valid = !fifo_empty;

endmodule

// File: tb/tb_sram_rw0_ctrl.sv
// Bench for sram_rw0_ctrl: behavioural RW0 macro, table vectors, scoreboard queue.
module tb_sram_rw0_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [71:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [71:0] resp_rdata;
  logic        init_done;
  logic [7:0]  RW0_addr;
  logic        RW0_en;
  logic        RW0_wmode;
  logic [71:0] RW0_wdata;
  logic [71:0] RW0_rdata = '0;

  int passed = 0;
  int total  = 0;

  logic [71:0] sram    [256];
  logic [71:0] ref_mem [256];
  logic [71:0] exp_q   [$];
  logic [71:0] mon_exp;

  typedef struct {
    logic        wen;
    logic [7:0]  addr;
    logic [71:0] wdata;
    logic [71:0] exp;
  } vec_t;
  vec_t tv [8];

  always #5 clock = ~clock;

  sram_rw0_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .init_done  (init_done),
    .RW0_addr   (RW0_addr),
    .RW0_en     (RW0_en),
    .RW0_wmode  (RW0_wmode),
    .RW0_wdata  (RW0_wdata),
    .RW0_rdata  (RW0_rdata)
  );

  // Macro model: garbage contents during reset, read data registered,
  // read data clobbered by any write.
  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) sram[i] <= {8'($urandom), $urandom, $urandom};
    end else if (RW0_en) begin
      if (RW0_wmode) begin
        sram[RW0_addr] <= RW0_wdata;
        RW0_rdata      <= {8'($urandom), $urandom, $urandom};
      end else begin
        RW0_rdata <= sram[RW0_addr];
      end
    end
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clock) begin
    if (reset_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 96'd1, 96'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("resp_data", resp_rdata, mon_exp);
      end
    end
  end

  // Entered at posedge+1 with reset just released.
  task automatic run_init();
    for (int i = 0; i < 256; i++) begin
      #1;
      check("init_wr", {RW0_en, RW0_wmode, RW0_addr, RW0_wdata, init_done, req_ready},
            {1'b1, 1'b1, 8'(i), 72'h0, 1'b0, 1'b0});
      @(posedge clock); #1;
    end
    check("init_done", init_done, 1'b1);
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
  endtask

  task automatic issue(input logic wen, input logic [7:0] a, input logic [71:0] wd,
                       input logic [71:0] e, input bit use_e);
    int n;
    n = 0;
    req_valid = 1'b1; req_wen = wen; req_addr = a; req_wdata = wd;
    #1;
    while (!req_ready && n < 40) begin
      resp_ready = 1'b1;
      @(posedge clock); #2;
      n++;
    end
    if (!req_ready) check("req_timeout", 96'd0, 96'd1);
    else if (wen) ref_mem[a] = wd;
    else exp_q.push_back(use_e ? e : ref_mem[a]);
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    resp_ready = 1'b1;
    while ((exp_q.size() != 0 || resp_valid) && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    check("drain_idle", resp_valid, 1'b0);
  endtask

  initial begin
    logic [4:0] acc;
    int drops;

    tv[0] = '{1'b1, 8'h10, 72'hAB_CDEF_0123_4567_89AB, 72'h0};
    tv[1] = '{1'b0, 8'h10, 72'h0, 72'hAB_CDEF_0123_4567_89AB};
    tv[2] = '{1'b1, 8'h20, 72'h5, 72'h0};
    tv[3] = '{1'b0, 8'h20, 72'h0, 72'h5};
    tv[4] = '{1'b1, 8'h20, 72'h9, 72'h0};
    tv[5] = '{1'b0, 8'h20, 72'h0, 72'h9};
    tv[6] = '{1'b0, 8'h80, 72'h0, 72'h0};
    tv[7] = '{1'b0, 8'h00, 72'h0, 72'h0};

    repeat (3) @(posedge clock);
    #1;
    check("rst_outputs", {req_ready, resp_valid, init_done, RW0_en, RW0_wmode, RW0_addr, RW0_wdata},
          '0);
    reset_n = 1'b1;
    run_init();

    // Post-init read of a zero-filled location
    issue(1'b0, 8'h80, 72'h0, 72'h0, 1'b1);
    wait_drain();

    for (int i = 0; i < 8; i++) issue(tv[i].wen, tv[i].addr, tv[i].wdata, tv[i].exp, 1'b1);
    wait_drain();

    // Read latency: accept at t, resp_valid at t+2
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 8'h10;
    #1;
    check("lat_ready", req_ready, 1'b1);
    exp_q.push_back(72'hAB_CDEF_0123_4567_89AB);
    @(posedge clock); #1;
    req_valid = 1'b0;
    check("lat_t1", resp_valid, 1'b0);
    @(posedge clock); #1;
    check("lat_t2", resp_valid, 1'b1);
    wait_drain();

    // Backpressure
    for (int i = 0; i < 5; i++) issue(1'b1, 8'h40 + 8'(i), 72'h100 + 72'(i), 72'h0, 1'b0);
    resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 8'h40 + 8'(i);
      #1;
      acc[i] = req_ready;
      if (req_ready) exp_q.push_back(ref_mem[req_addr]);
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    check("bp_accepted", acc, 5'b00111);
    repeat (2) @(posedge clock);
    #1;
    check("bp_rd_ready", req_ready, 1'b0);
    check("bp_valid", resp_valid, 1'b1);
    check("bp_head", resp_rdata, 72'h100);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 8'h30; req_wdata = 72'h3C3C;
    #1;
    check("bp_wr_ready", req_ready, 1'b1);
    if (req_ready) ref_mem[8'h30] = 72'h3C3C;
    @(posedge clock); #1;
    req_valid = 1'b0;
    check("bp_head_stable", resp_rdata, 72'h100);
    resp_ready = 1'b1;
    issue(1'b0, 8'h43, 72'h0, 72'h0, 1'b0);
    issue(1'b0, 8'h44, 72'h0, 72'h0, 1'b0);
    issue(1'b0, 8'h30, 72'h0, 72'h0, 1'b0);
    wait_drain();

    // Sustained reads
    drops = 0;
    for (int i = 0; i < 100; i++) begin
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 8'(i);
      #1;
      if (!req_ready) drops++;
      else exp_q.push_back(ref_mem[i]);
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    check("sweep_drops", drops, 0);
    wait_drain();

    // Random mix on a small address window
    for (int i = 0; i < 60; i++) begin
      resp_ready = ($urandom_range(0, 3) != 0);
      issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
            {8'($urandom), $urandom, $urandom}, 72'h0, 1'b0);
    end
    wait_drain();

    // Reset with two responses buffered and one in flight
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 8'h40 + 8'(i);
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    check("mid_valid_before", resp_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_outputs", {resp_valid, RW0_en, req_ready, init_done}, 4'b0000);
    exp_q.delete();
    resp_ready = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b1;
    run_init();
    repeat (3) begin
      check("no_stale", resp_valid, 1'b0);
      @(posedge clock); #1;
    end
    issue(1'b0, 8'h10, 72'h0, 72'h0, 1'b1);
    wait_drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
